// File: rtl/aer_conv_event_scheduler_pkg.sv
// aer_conv_event_scheduler_pkg: shared scan state type and width helpers for the AER conv scheduler.
package aer_conv_event_scheduler_pkg;
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_e;
   function automatic int out_dim(input int in_dim, input int k);
      return in_dim - k + 1;
   endfunction
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/aer_event_fifo.sv
// aer_event_fifo: synchronous FIFO with registered full/empty flags.
// Ports: work_clk, rst_n (async, active-low); i_push/i_data write side; i_pop/o_data read side
// (o_data is the current head); o_full/o_empty are registered, so a write is never visible
// to the reader in the same cycle.
module aer_event_fifo
   import aer_conv_event_scheduler_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         work_clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = width_of(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt, w_cnt;
   assign w_cnt  = r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
   assign o_data = r_mem[r_rp];
   always_ff @(posedge work_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         o_full  <= 1'b0;
         o_empty <= 1'b1;
      end else begin
         if (i_push) r_wp <= r_wp + 1'b1;
         if (i_pop) r_rp <= r_rp + 1'b1;
         r_cnt   <= w_cnt;
         o_full  <= w_cnt == (AW+1)'(DEPTH);
         o_empty <= w_cnt == '0;
      end
   end
   always_ff @(posedge work_clk)
      if (i_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/aer_conv_event_scheduler.sv
// aer_conv_event_scheduler: queues AER events and scans every channel/kernel tap into conv-core ops.
// Ports: work_clk, rst_n (async, active-low); i_ev_valid/o_ev_ready/i_ev_addr {x,y} event input;
// o_op_valid/i_op_ready with o_op_waddr, o_op_vaddr, o_op_m, o_op_n operation output;
// o_event_done end-of-scan pulse; o_err_coord sticky out-of-range flag; o_busy activity flag.
module aer_conv_event_scheduler
   import aer_conv_event_scheduler_pkg::*;
#(
   parameter  int COORD_W    = 8,
   parameter  int IN_DIM     = 28,
   parameter  int K          = 5,
   parameter  int CH         = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int OD         = out_dim(IN_DIM, K),
   localparam int WADDR_W    = width_of(CH * K * K),
   localparam int VADDR_W    = width_of(CH * OD * OD)
) (
   input  logic                 work_clk,
   input  logic                 rst_n,
   input  logic                 i_ev_valid,
   output logic                 o_ev_ready,
   input  logic [2*COORD_W-1:0] i_ev_addr,
   output logic                 o_op_valid,
   input  logic                 i_op_ready,
   output logic [WADDR_W-1:0]   o_op_waddr,
   output logic [VADDR_W-1:0]   o_op_vaddr,
   output logic [COORD_W-1:0]   o_op_m,
   output logic [COORD_W-1:0]   o_op_n,
   output logic                 o_event_done,
   output logic                 o_err_coord,
   output logic                 o_busy
);
   localparam int KW   = width_of(K);
   localparam int SW   = COORD_W + 1;
   localparam int NOPS = CH * K * K;
   localparam logic [VADDR_W-1:0] ROW_STEP = VADDR_W'(OD);
   // Going from the last tap row (m = x-(K-1)) to row 0 of the next channel.
   localparam logic [VADDR_W-1:0] CH_STEP  = VADDR_W'(OD * OD + (K - 1) * OD);
   scan_state_e          r_state, w_state;
   logic                 w_full, w_empty, w_push, w_pop, w_adv, w_last, w_step, w_jw, w_iw, w_oob, w_inr;
   logic [2*COORD_W-1:0] w_head;
   logic [COORD_W-1:0]   r_x, r_y, w_hx, w_hy;
   logic [KW-1:0]        r_i, r_j, w_i, w_j;
   // Output row/col kept as signed COORD_W+1 two's complement; negative means clipped.
   logic [SW-1:0]        r_m, r_n, w_m, w_n;
   // Vmem addresses wrap modulo 2^VADDR_W; they are exact whenever the position is in range.
   logic [VADDR_W-1:0]   r_vrow, r_vaddr, w_vrow, w_vaddr, w_hrow;
   logic [WADDR_W-1:0]   r_waddr, w_waddr;
   logic                 r_op_valid, r_done, r_err;
   assign w_oob  = i_ev_addr[2*COORD_W-1:COORD_W] >= COORD_W'(IN_DIM) ||
                   i_ev_addr[COORD_W-1:0] >= COORD_W'(IN_DIM);
   assign w_push = i_ev_valid && o_ev_ready && !w_oob;
   assign {w_hx, w_hy} = w_head;
   aer_event_fifo #(.W(2 * COORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .work_clk(work_clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (i_ev_addr),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   // Next scan position; the weight address is simply the flattened c/i/j counter.
   always_comb begin
      w_adv   = r_state == SCAN && (!r_op_valid || i_op_ready);
      w_last  = r_waddr == WADDR_W'(NOPS - 1);
      w_pop   = !w_empty && (r_state == IDLE || (w_adv && w_last));
      w_step  = w_pop || (w_adv && !w_last);
      w_jw    = r_j == KW'(K - 1);
      w_iw    = r_i == KW'(K - 1);
      w_hrow  = VADDR_W'(w_hx) * ROW_STEP;
      w_waddr = w_pop ? '0 : r_waddr + 1'b1;
      w_i     = (w_pop || (w_jw && w_iw)) ? '0 : w_jw ? r_i + 1'b1 : r_i;
      w_j     = (w_pop || w_jw) ? '0 : r_j + 1'b1;
      w_m     = w_pop ? {1'b0, w_hx} : !w_jw ? r_m : w_iw ? {1'b0, r_x} : r_m - 1'b1;
      w_n     = w_pop ? {1'b0, w_hy} : w_jw ? {1'b0, r_y} : r_n - 1'b1;
      w_vrow  = w_pop ? w_hrow : !w_jw ? r_vrow : w_iw ? r_vrow + CH_STEP : r_vrow - ROW_STEP;
      w_vaddr = w_pop ? w_hrow + VADDR_W'(w_hy) : w_jw ? w_vrow + VADDR_W'(r_y) : r_vaddr - 1'b1;
      w_inr   = !w_m[SW-1] && !w_n[SW-1] &&
                w_m[COORD_W-1:0] < COORD_W'(OD) && w_n[COORD_W-1:0] < COORD_W'(OD);
   end
   always_ff @(posedge work_clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state;
   always_comb w_state = w_pop ? SCAN : (w_adv && w_last) ? IDLE : r_state;
   always_comb begin
      o_ev_ready   = !w_full;
      o_op_valid   = r_op_valid;
      o_op_waddr   = r_waddr;
      o_op_vaddr   = r_vaddr;
      o_op_m       = r_m[COORD_W-1:0];
      o_op_n       = r_n[COORD_W-1:0];
      o_event_done = r_done;
      o_err_coord  = r_err;
      o_busy       = r_state != IDLE || !w_empty;
   end
   always_ff @(posedge work_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_i        <= '0;
         r_j        <= '0;
         r_m        <= '0;
         r_n        <= '0;
         r_vrow     <= '0;
         r_vaddr    <= '0;
         r_waddr    <= '0;
         r_op_valid <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= w_adv && w_last;
         r_err  <= r_err || (i_ev_valid && o_ev_ready && w_oob);
         if (w_step) begin
            r_i        <= w_i;
            r_j        <= w_j;
            r_m        <= w_m;
            r_n        <= w_n;
            r_vrow     <= w_vrow;
            r_vaddr    <= w_vaddr;
            r_waddr    <= w_waddr;
            r_op_valid <= w_inr;
         end else if (w_adv && w_last) begin
            r_op_valid <= 1'b0;
         end
         if (w_pop) begin
            r_x <= w_hx;
            r_y <= w_hy;
         end
      end
   end
endmodule

// File: tb/tb_aer_conv_event_scheduler.sv
// tb_aer_conv_event_scheduler: randomized self-checking bench against a per-event op-list reference model.
module tb_aer_conv_event_scheduler;
   localparam int K = 5, CH = 4, IN = 28, OD = IN - K + 1;
   logic        work_clk = 1'b0, rst_n = 1'b0, i_ev_valid = 1'b0, i_op_ready = 1'b1;
   logic [15:0] i_ev_addr = '0;
   logic        o_ev_ready, o_op_valid, o_event_done, o_err_coord, o_busy;
   logic [6:0]  o_op_waddr;
   logic [11:0] o_op_vaddr;
   logic [7:0]  o_op_m, o_op_n;
   int          n_checks = 0, n_err = 0, n_done = 0, mode = 0;
   logic [63:0] exp_q[$];
   logic        r_stalled = 1'b0;
   logic [63:0] r_prev = '0;

   aer_conv_event_scheduler dut (
      .work_clk    (work_clk),
      .rst_n       (rst_n),
      .i_ev_valid  (i_ev_valid),
      .o_ev_ready  (o_ev_ready),
      .i_ev_addr   (i_ev_addr),
      .o_op_valid  (o_op_valid),
      .i_op_ready  (i_op_ready),
      .o_op_waddr  (o_op_waddr),
      .o_op_vaddr  (o_op_vaddr),
      .o_op_m      (o_op_m),
      .o_op_n      (o_op_n),
      .o_event_done(o_event_done),
      .o_err_coord (o_err_coord),
      .o_busy      (o_busy)
   );

   always #5 work_clk = ~work_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every in-range (c,i,j) tap of an event, in scan order, as {waddr, vaddr, m, n}.
   task automatic model_event(input int x, input int y);
      if (x < IN && y < IN)
         for (int c = 0; c < CH; c++)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++) begin
                  int m, n;
                  m = x - i;
                  n = y - j;
                  if (m >= 0 && m < OD && n >= 0 && n < OD)
                     exp_q.push_back({16'(c * K * K + i * K + j), 16'(c * OD * OD + m * OD + n), 16'(m), 16'(n)});
               end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic push(input int x, input int y);
      int n = 0;
      i_ev_valid = 1'b1;
      i_ev_addr  = {8'(x), 8'(y)};
      while (!o_ev_ready && n < 1000) begin
         @(posedge work_clk);
         #1;
         n++;
      end
      check("push_accept", 64'(o_ev_ready), 64'd1);
      @(posedge work_clk);
      #1;
      i_ev_valid = 1'b0;
      model_event(x, y);
   endtask

   task automatic wait_idle();
      int cnt = 0;
      do begin
         @(negedge work_clk);
         cnt++;
      end while ((o_busy || exp_q.size() != 0) && cnt < 20000);
      check("idle", 64'(o_busy), 64'd0);
      check("sb_drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Single event into an idle block: first op two cycles after acceptance, done after CH*K*K scan cycles.
   task automatic single(input int x, input int y);
      int cnt;
      push(x, y);
      @(negedge work_clk);
      check("lat_idle", 64'(o_op_valid), 64'd0);
      @(negedge work_clk);
      check("lat_first", 64'(o_op_valid), 64'd1);
      cnt = 2;
      do begin
         @(negedge work_clk);
         cnt++;
      end while (!o_event_done && cnt < 400);
      check("done_lat", 64'(cnt), 64'(CH * K * K + 2));
      check("idle_after", 64'(o_busy), 64'd0);
      check("sb_single", 64'(exp_q.size()), 64'd0);
      @(posedge work_clk);
      #1;
   endtask

   task automatic wait_dones(input int k, output int cnt);
      int seen = 0;
      cnt = 0;
      while (seen < k && cnt < 5000) begin
         @(negedge work_clk);
         cnt++;
         if (o_event_done) seen++;
      end
   endtask

   initial forever begin
      @(posedge work_clk);
      #1;
      i_op_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom & 1) : 1'b0;
   end

   always @(negedge work_clk) begin
      logic [63:0] got, exp;
      if (!rst_n) r_stalled = 1'b0;
      else begin
         got = {16'(o_op_waddr), 16'(o_op_vaddr), 16'(o_op_m), 16'(o_op_n)};
         if (r_stalled) begin
            check("stall_valid", 64'(o_op_valid), 64'd1);
            check("stall_hold", got, r_prev);
         end
         if (o_op_valid && i_op_ready) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("op", got, exp);
         end
         r_stalled = o_op_valid && !i_op_ready;
         r_prev    = got;
         if (o_event_done) n_done++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, k, d0, cyc;
      logic rdy;
      int xs[6], ys[6];
      repeat (3) @(posedge work_clk);
      #1 rst_n = 1'b1;
      @(negedge work_clk);
      check("rst_ready", 64'(o_ev_ready), 64'd1);
      check("rst_valid", 64'(o_op_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_err", 64'(o_err_coord), 64'd0);
      check("rst_done", 64'(o_event_done), 64'd0);
      @(posedge work_clk);
      #1;
      single(0, 0);
      single(10, 10);
      push(27, 27);
      wait_idle();
      @(posedge work_clk);
      #1;
      mode = 1;
      d0 = n_done;
      for (int e = 0; e < 12; e++) begin
         push($urandom_range(0, IN - 1), $urandom_range(0, IN - 1));
         repeat ($urandom_range(0, 40)) begin
            @(posedge work_clk);
            #1;
         end
      end
      wait_idle();
      @(posedge work_clk);
      #1;
      check("rand_dones", 64'(n_done - d0), 64'd12);
      mode = 0;
      push(30, 5);
      check("oob_err", 64'(o_err_coord), 64'd1);
      check("oob_busy", 64'(o_busy), 64'd0);
      push(1, 1);
      wait_idle();
      check("err_sticky", 64'(o_err_coord), 64'd1);
      mode = 2;
      @(posedge work_clk);
      #1;
      xs[0] = 10;
      ys[0] = 10;
      for (int e = 1; e < 6; e++) begin
         xs[e] = $urandom_range(0, IN - 1);
         ys[e] = $urandom_range(0, IN - 1);
      end
      acc = 0;
      k = 0;
      for (cyc = 0; cyc < 10; cyc++) begin
         i_ev_valid = 1'b1;
         i_ev_addr  = {8'(xs[k]), 8'(ys[k])};
         rdy = o_ev_ready;
         @(posedge work_clk);
         #1;
         if (rdy) begin
            model_event(xs[k], ys[k]);
            acc++;
            if (k < 5) k++;
         end
      end
      i_ev_valid = 1'b0;
      check("full_accepted", 64'(acc), 64'd5);
      check("full_ready", 64'(o_ev_ready), 64'd0);
      repeat (5) @(posedge work_clk);
      @(negedge work_clk);
      check("stalled_valid", 64'(o_op_valid), 64'd1);
      mode = 0;
      wait_dones(5, cyc);
      check("drain_cycles", 64'(cyc), 64'(5 * CH * K * K + 1));
      check("sb_drain5", 64'(exp_q.size()), 64'd0);
      @(posedge work_clk);
      #1;
      push(10, 10);
      push($urandom_range(0, IN - 1), $urandom_range(0, IN - 1));
      push($urandom_range(0, IN - 1), $urandom_range(0, IN - 1));
      repeat (20) begin
         @(posedge work_clk);
         #1;
      end
      check("pre_rst_busy", 64'(o_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(o_op_valid), 64'd0);
      check("mid_rst_busy", 64'(o_busy), 64'd0);
      check("mid_rst_err", 64'(o_err_coord), 64'd0);
      check("mid_rst_done", 64'(o_event_done), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge work_clk);
      #1 rst_n = 1'b1;
      @(negedge work_clk);
      check("post_rst_ready", 64'(o_ev_ready), 64'd1);
      check("post_rst_busy", 64'(o_busy), 64'd0);
      @(posedge work_clk);
      #1;
      single(0, 0);
      check("sb_final", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
